// File: rtl/eee_imgproc_pkg.sv
// Image-processor register map, RBB message layout and the message-reader FSM state type.
// Shared by the hardware message reader and anything else that talks to the processor.
package eee_imgproc_pkg;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] READ_MSG   = 3'd1;
    localparam logic [2:0] READ_ID    = 3'd2;
    localparam logic [2:0] REG_BBCOL  = 3'd3;

    localparam logic [31:0] MSG_ID_RBB = 32'h0052_4242;

    localparam int unsigned FLUSH_BIT = 4;
    localparam int unsigned WORDS_MSB = 15;
    localparam int unsigned WORDS_LSB = 8;

    localparam logic [31:0] FLUSH_WORD = 32'h1 << FLUSH_BIT;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned X_MSB   = 26;
    localparam int unsigned X_LSB   = 16;
    localparam int unsigned Y_MSB   = 10;
    localparam int unsigned Y_LSB   = 0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [3:0] {
        StIdle,
        StStatRd,
        StStatWt,
        StIdRd,
        StIdWt,
        StTlRd,
        StTlWt,
        StBrRd,
        StBrWt,
        StPublish,
        StFlushWr
    } rdr_state_e;

    function automatic coord_t coord_x(input logic [31:0] word);
        return word[X_MSB:X_LSB];
    endfunction

    function automatic coord_t coord_y(input logic [31:0] word);
        return word[Y_MSB:Y_LSB];
    endfunction

    function automatic logic [7:0] status_words(input logic [31:0] word);
        return word[WORDS_MSB:WORDS_LSB];
    endfunction

endpackage

// File: rtl/eee_msg_reader_if.sv
// Avalon-MM bus between the message reader (master) and the image processor's register slave.
interface eee_msg_reader_if;

    logic        m_chipselect;
    logic [2:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    modport master (
        output m_chipselect,
        output m_address,
        output m_read,
        output m_write,
        output m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_chipselect,
        input  m_address,
        input  m_read,
        input  m_write,
        input  m_writedata,
        output m_readdata
    );

endinterface

// File: rtl/eee_msg_reader.sv
// Hardware drain of the image processor's message FIFO: polls STATUS, reads RBB messages and
// publishes the latest bounding box. Define EEE_MSG_READER_FLUSH_EN to flush the FIFO on a bad ID.
module eee_msg_reader
    import eee_imgproc_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter logic [31:0] MSG_ID        = MSG_ID_RBB,
    parameter logic [10:0] IMAGE_W       = 11'd640,
    parameter logic [10:0] IMAGE_H       = 11'd480
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    eee_msg_reader_if.master        m_bus,
    output logic [10:0]             bb_left,
    output logic [10:0]             bb_top,
    output logic [10:0]             bb_right,
    output logic [10:0]             bb_bottom,
    output logic                    bb_valid,
    output logic                    bb_found,
    output logic [7:0]              err_count,
    output logic                    busy
);

    localparam int unsigned CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_INTERVAL - 1);

    rdr_state_e       r_state;
    rdr_state_e       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    coord_t           r_x0;
    coord_t           r_y0;
    coord_t           r_bb_left;
    coord_t           r_bb_top;
    coord_t           r_bb_right;
    coord_t           r_bb_bottom;
    logic             r_bb_valid;
    logic             r_bb_found;
    logic [7:0]       r_err;

    logic             w_read;
    logic             w_write;
    logic [2:0]       w_addr;
    logic [31:0]      w_wdata;
    coord_t           w_x;
    coord_t           w_y;
    logic [7:0]       w_words;
    logic             w_id_ok;

    assign w_x     = coord_x(m_bus.m_readdata);
    assign w_y     = coord_y(m_bus.m_readdata);
    assign w_words = status_words(m_bus.m_readdata);
    assign w_id_ok = (m_bus.m_readdata == MSG_ID);

    // Next-state, poll counter and bus strobes; address stays put across each RD/WT pair.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_read    = 1'b0;
        w_write   = 1'b0;
        w_addr    = REG_STATUS;
        w_wdata   = '0;
        unique case (r_state)
            StIdle: begin
                if (!enable) begin
                    w_cnt_d = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = StStatRd;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StStatRd: begin
                w_read    = 1'b1;
                w_state_d = StStatWt;
            end
            StStatWt: begin
                if (w_words >= 8'd3) begin
                    w_state_d = StIdRd;
                end else begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end
            end
            StIdRd: begin
                w_read    = 1'b1;
                w_addr    = READ_MSG;
                w_state_d = StIdWt;
            end
            StIdWt: begin
                w_addr = READ_MSG;
                if (w_id_ok) begin
                    w_state_d = StTlRd;
                end else begin
`ifdef EEE_MSG_READER_FLUSH_EN
                    w_state_d = StFlushWr;
`else
                    // Re-poll; each mismatch consumes one word until alignment recovers.
                    w_state_d = StStatRd;
`endif
                end
            end
            StTlRd: begin
                w_read    = 1'b1;
                w_addr    = READ_MSG;
                w_state_d = StTlWt;
            end
            StTlWt: begin
                w_addr    = READ_MSG;
                w_state_d = StBrRd;
            end
            StBrRd: begin
                w_read    = 1'b1;
                w_addr    = READ_MSG;
                w_state_d = StBrWt;
            end
            StBrWt: begin
                w_addr    = READ_MSG;
                w_state_d = StPublish;
            end
            StPublish: begin
                // Drain any backlog straight away instead of waiting out a poll interval.
                w_state_d = StStatRd;
            end
            StFlushWr: begin
                w_write   = 1'b1;
                w_wdata   = FLUSH_WORD;
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_bb_left   <= IMAGE_W - 11'd1;
            r_bb_top    <= IMAGE_H - 11'd1;
            r_bb_right  <= '0;
            r_bb_bottom <= '0;
            r_bb_valid  <= 1'b0;
            r_bb_found  <= 1'b0;
            r_err       <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_bb_valid <= 1'b0;
            if (r_state == StIdWt && !w_id_ok && r_err != 8'hFF) begin
                r_err <= r_err + 8'd1;
            end
            if (r_state == StTlWt) begin
                r_x0 <= w_x;
                r_y0 <= w_y;
            end
            // The bottom-right word goes straight to the outputs so the new box and its
            // strobe are both visible during PUBLISH.
            if (r_state == StBrWt) begin
                r_bb_left   <= r_x0;
                r_bb_top    <= r_y0;
                r_bb_right  <= w_x;
                r_bb_bottom <= w_y;
                r_bb_found  <= (r_x0 <= w_x) && (r_y0 <= w_y);
                r_bb_valid  <= 1'b1;
            end
        end
    end

    // Strobes are gated by reset so an abort drops them in the same cycle.
    assign m_bus.m_read      = w_read & ~reset;
`ifdef EEE_MSG_READER_FLUSH_EN
    assign m_bus.m_write     = w_write & ~reset;
    assign m_bus.m_writedata = w_wdata;
`else
    assign m_bus.m_write     = 1'b0;
    assign m_bus.m_writedata = (w_write ? w_wdata : 32'h0) & 32'h0;
`endif
    assign m_bus.m_address    = w_addr;
    assign m_bus.m_chipselect = m_bus.m_read | m_bus.m_write;

    assign bb_left   = r_bb_left;
    assign bb_top    = r_bb_top;
    assign bb_right  = r_bb_right;
    assign bb_bottom = r_bb_bottom;
    assign bb_valid  = r_bb_valid;
    assign bb_found  = r_bb_found;
    assign err_count = r_err;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_eee_msg_reader.sv
// Directed bench for eee_msg_reader: model FIFO slave, table of messages, plus hand-written
// sequences for backlog drain, short FIFO, enable gating and reset mid-message.
module tb_eee_msg_reader;

    localparam int unsigned P = 16;
    localparam logic [31:0] MSG = 32'h0052_4242;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [10:0] bb_left, bb_top, bb_right, bb_bottom;
    logic        bb_valid, bb_found, busy;
    logic [7:0]  err_count;

    eee_msg_reader_if bus ();

    eee_msg_reader #(.POLL_INTERVAL(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .m_bus     (bus),
        .bb_left   (bb_left),
        .bb_top    (bb_top),
        .bb_right  (bb_right),
        .bb_bottom (bb_bottom),
        .bb_valid  (bb_valid),
        .bb_found  (bb_found),
        .err_count (err_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model: registered readdata, pops on read ----------------
    logic [31:0] fifo_q[$];
    logic [31:0] rdata;
    assign bus.m_readdata = rdata;

    function automatic logic [7:0] words8();
        int sz;
        sz = fifo_q.size();
        return (sz > 255) ? 8'hFF : 8'(sz);
    endfunction

    initial rdata = 32'h0;
    always @(posedge clk) begin
        if (bus.m_write && bus.m_address == 3'd0 && bus.m_writedata[4]) fifo_q.delete();
        if (bus.m_read) begin
            if (bus.m_address == 3'd0) rdata <= {16'h0, words8(), 8'h0};
            else if (fifo_q.size() > 0) rdata <= fifo_q.pop_front();
            else rdata <= 32'h0;
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0, nacc = 0, nstat = 0, nmsg = 0, nwr = 0, vcount = 0;
    int          last_stat = 0, run = 0, last_idle = 0, dbl_rd = 0, long_valid = 0;
    logic        prev_rd = 1'b0, prev_valid = 1'b0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  acc_log [0:4095];
    int          vcyc [0:63];
    int          vlat [0:63];
    logic [10:0] vl [0:63];
    logic [10:0] vr [0:63];

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_rd    <= bus.m_read;
        prev_valid <= bb_valid;
        if (prev_rd && bus.m_read) dbl_rd <= dbl_rd + 1;
        if (prev_valid && bb_valid) long_valid <= long_valid + 1;
        if (bus.m_read || bus.m_write) begin
            if (nacc < 4096) acc_log[nacc] <= {bus.m_write, bus.m_address};
            nacc <= nacc + 1;
        end
        if (bus.m_read && bus.m_address == 3'd0) begin
            nstat     <= nstat + 1;
            last_stat <= cyc;
        end
        if (bus.m_read && bus.m_address == 3'd1) nmsg <= nmsg + 1;
        if (bus.m_write) begin
            nwr        <= nwr + 1;
            last_wdata <= bus.m_writedata;
        end
        if (bb_valid) begin
            if (vcount < 64) begin
                vcyc[vcount] <= cyc;
                vlat[vcount] <= cyc - last_stat;
                vl[vcount]   <= bb_left;
                vr[vcount]   <= bb_right;
            end
            vcount <= vcount + 1;
        end
        if (!busy) run <= run + 1;
        else if (run != 0) begin
            last_idle <= run;
            run       <= 0;
        end
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        fifo_q.push_back(c);
    endtask

    typedef struct {
        logic [31:0] id;
        logic [31:0] tl;
        logic [31:0] br;
        int          pulses;
        logic [10:0] l, t, r, b;
        logic        found;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int v0, w0, a0, s0, m0, n, hit;
        logic [3:0] nxt;

        reset  = 1'b1;
        enable = 1'b0;

        vecs[0] = '{MSG, 32'h0064_0032, 32'h00C8_0096, 1, 11'd100, 11'd50, 11'd200, 11'd150, 1'b1, 8'd0};
        vecs[1] = '{MSG, 32'h027F_01DF, 32'h0000_0000, 1, 11'd639, 11'd479, 11'd0, 11'd0, 1'b0, 8'd0};
        // Bits [31:27] and [15:11] set: must be ignored.
        vecs[2] = '{MSG, 32'hF864_F832, 32'h07FF_07FF, 1, 11'd100, 11'd50, 11'd2047, 11'd2047, 1'b1, 8'd0};
        vecs[3] = '{MSG, 32'h0005_0007, 32'h0005_0007, 1, 11'd5, 11'd7, 11'd5, 11'd7, 1'b1, 8'd0};
        vecs[4] = '{MSG, 32'h0001_0009, 32'h0002_0008, 1, 11'd1, 11'd9, 11'd2, 11'd8, 1'b0, 8'd0};
        // Bad ID: outputs hold the previous box.
        vecs[5] = '{32'hDEAD_BEEF, 32'h0011_0022, 32'h0033_0044, 0, 11'd1, 11'd9, 11'd2, 11'd8, 1'b0, 8'd1};

        tick(3);
        chk("rst_left", 0, 32'(bb_left), 32'd639);
        chk("rst_top", 0, 32'(bb_top), 32'd479);
        chk("rst_right", 0, 32'(bb_right), 32'd0);
        chk("rst_bottom", 0, 32'(bb_bottom), 32'd0);
        chk("rst_valid_found", 0, {30'd0, bb_valid, bb_found}, 32'd0);
        chk("rst_err", 0, 32'(err_count), 32'd0);
        chk("rst_bus", 0, {29'd0, busy, bus.m_read, bus.m_chipselect}, 32'd0);

        reset  = 1'b0;
        enable = 1'b1;
        tick(2 * P);

        for (int i = 0; i < 6; i++) begin
            v0 = vcount;
            w0 = nwr;
            a0 = nacc;
            load3(vecs[i].id, vecs[i].tl, vecs[i].br);
            tick(60);
            chk("pulses", i, vcount - v0, vecs[i].pulses);
            chk("left", i, 32'(bb_left), 32'(vecs[i].l));
            chk("top", i, 32'(bb_top), 32'(vecs[i].t));
            chk("right", i, 32'(bb_right), 32'(vecs[i].r));
            chk("bottom", i, 32'(bb_bottom), 32'(vecs[i].b));
            chk("found", i, 32'(bb_found), 32'(vecs[i].found));
            chk("err_count", i, 32'(err_count), 32'(vecs[i].err));
            if (vecs[i].pulses == 0) begin
                nxt = 4'hF;
                for (int k = a0; k < nacc - 1 && k < 4095; k++) begin
                    if (acc_log[k] == 4'b0001) begin
                        nxt = acc_log[k + 1];
                        break;
                    end
                end
`ifdef EEE_MSG_READER_FLUSH_EN
                chk("after_bad_id", i, 32'(nxt), 32'b1000);
                chk("flush_writes", i, nwr - w0, 1);
                chk("flush_data", i, last_wdata, 32'h10);
`else
                chk("after_bad_id", i, 32'(nxt), 32'b0000);
                chk("no_writes", i, nwr - w0, 0);
`endif
            end
            fifo_q.delete();
        end

        // Two queued messages: drained back to back, PUBLISH is cycle 9 counting ST_RD as 1.
        v0 = vcount;
        load3(MSG, 32'h000A_0014, 32'h001E_0028);
        load3(MSG, 32'h0001_0002, 32'h0003_0004);
        tick(80);
        chk("two_pulses", 0, vcount - v0, 2);
        if (v0 < 62) begin
            chk("pulse_gap", 0, vcyc[v0 + 1] - vcyc[v0], 9);
            chk("latency1", 0, vlat[v0], 8);
            chk("latency2", 0, vlat[v0 + 1], 8);
            chk("msg1_left", 0, 32'(vl[v0]), 32'd10);
            chk("msg2_right", 0, 32'(vr[v0 + 1]), 32'd3);
        end

        // Two words only: never touch READ_MSG; idle exactly P cycles between polls.
        m0 = nmsg;
        fifo_q.push_back(MSG);
        fifo_q.push_back(32'h0001_0001);
        tick(70);
        chk("short_no_msg_read", 0, nmsg - m0, 0);
        chk("poll_idle_cycles", 0, last_idle, P);
        fifo_q.delete();

        // enable low: no polling at all; re-enable gives one poll after P idle cycles.
        enable = 1'b0;
        tick(3);
        s0 = nstat;
        tick(50);
        chk("disabled_polls", 0, nstat - s0, 0);
        chk("disabled_busy", 0, 32'(busy), 0);
        enable = 1'b1;
        s0 = nstat;
        tick(P + 3);
        chk("reenable_polls", 0, nstat - s0, 1);

        chk("consecutive_reads", 0, dbl_rd, 0);
        chk("valid_width", 0, long_valid, 0);

        // Reset while in TL_WT: partial message dropped, outputs back to reset values.
        load3(MSG, 32'h0064_0032, 32'h00C8_0096);
        n = 0;
        hit = 0;
        for (int k = 0; k < 200 && hit == 0; k++) begin
            @(negedge clk);
            if (bus.m_read && bus.m_address == 3'd1) begin
                n++;
                if (n == 2) hit = 1;
            end
        end
        chk("reach_tl_wt", 0, hit, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_busy_rd", 0, {30'd0, busy, bus.m_read}, 0);
        chk("rstmid_left_top", 0, {10'd0, bb_left, bb_top}, {10'd0, 11'd639, 11'd479});
        chk("rstmid_right_bot", 0, {10'd0, bb_right, bb_bottom}, 0);
        chk("rstmid_err", 0, 32'(err_count), 0);
        reset = 1'b0;
        fifo_q.delete();
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
